// File: rtl/spq_writer_if.sv
// spq_writer_if: upstream byte stream, queue enqueue side and occupancy status of the writer
interface spq_writer_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    logic                   s_valid;
    logic [DATA_W-1:0]      s_data;
    logic                   s_ready;
    logic                   enqueue_sig;
    logic [DATA_W-1:0]      q_data;
    logic                   deq_pulse;
    logic [$clog2(DEPTH):0] occupancy;
    logic                   full;
    logic                   empty;
    logic                   underflow;
    modport slave (
        input  s_valid, s_data, deq_pulse,
        output s_ready, enqueue_sig, q_data, occupancy, full, empty, underflow
    );
    modport master (
        output s_valid, s_data, deq_pulse,
        input  s_ready, enqueue_sig, q_data, occupancy, full, empty, underflow
    );
endinterface

// File: rtl/spq_writer.sv
// spq_writer: turns accepted upstream bytes into single-cycle enqueue strobes with a quiet gap,
// and tracks queue occupancy from its own enqueues and consumer dequeues.
module spq_writer #(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    spq_writer_if.slave    spq
);
    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam int GAP_W = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, ENQ, GAP} state_t;
    state_t            state_q, state_d;
    logic [GAP_W-1:0]  gap_q;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [DATA_W-1:0] q_data_q;
    logic              enq_q, s_ready_q, underflow_q;
    logic              transfer, inc, dec;
    always_comb begin
        transfer = spq.s_valid & s_ready_q;
        inc      = state_q == ENQ;
        dec      = spq.deq_pulse & ((occ_q != '0) | inc);
        occ_d    = (inc & ~dec) ? occ_q + OCC_W'(1) :
                   (~inc & dec) ? occ_q - OCC_W'(1) : occ_q;
        state_d  = state_q == IDLE ? (transfer ? ENQ : IDLE) :
                   state_q == ENQ  ? GAP :
                   (gap_q == '0 ? IDLE : GAP);
    end
    // s_ready is precomputed from next state and next occupancy so it stays a pure register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gap_q       <= '0;
            occ_q       <= '0;
            q_data_q    <= '0;
            enq_q       <= 1'b0;
            s_ready_q   <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_q       <= state_q == ENQ ? GAP_W'(GAP_CYCLES - 1) :
                           (state_q == GAP && gap_q != '0) ? gap_q - GAP_W'(1) : gap_q;
            occ_q       <= occ_d;
            q_data_q    <= transfer ? spq.s_data : q_data_q;
            enq_q       <= state_d == ENQ;
            s_ready_q   <= state_d == IDLE && occ_d < OCC_W'(DEPTH);
            underflow_q <= underflow_q | (spq.deq_pulse & (occ_q == '0) & ~inc);
        end
    end
    always_ff @(posedge clk)
        if (rst_n) assert (!(state_q == ENQ && occ_q == OCC_W'(DEPTH)));
    assign spq.s_ready     = s_ready_q;
    assign spq.enqueue_sig = enq_q;
    assign spq.q_data      = q_data_q;
    assign spq.occupancy   = occ_q;
    assign spq.full        = occ_q == OCC_W'(DEPTH);
    assign spq.empty       = occ_q == '0;
    assign spq.underflow   = underflow_q;
endmodule

// File: tb/tb_spq_writer.sv
// tb_spq_writer: directed checks of strobe timing, fill/back-pressure, occupancy and underflow.
module tb_spq_writer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   strobes = 0;
    int   base;
    spq_writer_if #(.DATA_W(8), .DEPTH(16)) spq ();
    spq_writer #(.DATA_W(8), .DEPTH(16), .GAP_CYCLES(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .spq   (spq)
    );
    always #5 clk = ~clk;
    always @(negedge clk) strobes += int'(spq.enqueue_sig);
    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1);
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask
    task automatic put(input logic [7:0] d);
        spq.s_valid = 1'b1;
        spq.s_data  = d;
        step();
        spq.s_valid = 1'b0;
        step();
        step();
    endtask
    initial begin
        spq.s_valid   = 1'b0;
        spq.s_data    = '0;
        spq.deq_pulse = 1'b0;
        #12;
        chk("rst_enq", spq.enqueue_sig, 0);
        chk("rst_occ", spq.occupancy, 0);
        chk("rst_empty", spq.empty, 1);
        chk("rst_full", spq.full, 0);
        chk("rst_uf", spq.underflow, 0);
        chk("rst_qdata", spq.q_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rel_ready", spq.s_ready, 1);
        // single byte: strobe next cycle, one low cycle, ready back on the third
        spq.s_valid = 1'b1;
        spq.s_data  = 8'h5A;
        step();
        chk("one_enq", spq.enqueue_sig, 1);
        chk("one_qdata", spq.q_data, 8'h5A);
        chk("one_ready_enq", spq.s_ready, 0);
        spq.s_valid = 1'b0;
        step();
        chk("one_gap", spq.enqueue_sig, 0);
        chk("one_gap_q", spq.q_data, 8'h5A);
        chk("one_occ", spq.occupancy, 1);
        chk("one_ready_gap", spq.s_ready, 0);
        step();
        chk("one_ready_back", spq.s_ready, 1);
        chk("one_empty", spq.empty, 0);
        // reset in the middle of a strobe
        spq.s_valid = 1'b1;
        spq.s_data  = 8'h77;
        step();
        chk("mid_enq", spq.enqueue_sig, 1);
        spq.s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_enq", spq.enqueue_sig, 0);
        chk("mid_rst_occ", spq.occupancy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("mid_ready", spq.s_ready, 1);
        chk("mid_empty", spq.empty, 1);
        chk("mid_qdata", spq.q_data, 0);
        step();
        chk("mid_no_replay", spq.enqueue_sig, 0);
        // fill with back-to-back bytes
        base = strobes;
        spq.s_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            spq.s_data = 8'(i);
            step();
            chk("fill_enq", spq.enqueue_sig, 1);
            chk("fill_qdata", spq.q_data, i);
            spq.s_data = 8'hEE;
            step();
            chk("fill_gap", spq.enqueue_sig, 0);
            chk("fill_hold", spq.q_data, i);
            step();
        end
        chk("fill_strobes", strobes - base, 16);
        chk("fill_full", spq.full, 1);
        chk("fill_occ", spq.occupancy, 16);
        chk("fill_ready", spq.s_ready, 0);
        spq.s_data = 8'h10;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_enq", spq.enqueue_sig, 0);
            chk("hold_ready", spq.s_ready, 0);
        end
        chk("hold_strobes", strobes - base, 16);
        // one dequeue at full releases the held byte
        spq.deq_pulse = 1'b1;
        step();
        spq.deq_pulse = 1'b0;
        chk("unb_occ", spq.occupancy, 15);
        chk("unb_ready", spq.s_ready, 1);
        chk("unb_enq_early", spq.enqueue_sig, 0);
        step();
        chk("unb_enq", spq.enqueue_sig, 1);
        chk("unb_qdata", spq.q_data, 8'h10);
        spq.s_valid = 1'b0;
        step();
        step();
        chk("unb_full", spq.full, 1);
        chk("unb_strobes", strobes - base, 17);
        // dequeue coincident with the strobe at occupancy 4
        do_reset();
        for (int i = 0; i < 4; i++) put(8'(8'hA0 + i));
        chk("sim_occ4", spq.occupancy, 4);
        spq.s_valid = 1'b1;
        spq.s_data  = 8'hC3;
        step();
        spq.s_valid   = 1'b0;
        spq.deq_pulse = 1'b1;
        chk("sim_enq", spq.enqueue_sig, 1);
        step();
        spq.deq_pulse = 1'b0;
        chk("sim_occ", spq.occupancy, 4);
        chk("sim_uf", spq.underflow, 0);
        step();
        spq.deq_pulse = 1'b1;
        step();
        spq.deq_pulse = 1'b0;
        chk("deq_idle", spq.occupancy, 3);
        // underflow on an empty queue
        do_reset();
        spq.deq_pulse = 1'b1;
        step();
        chk("uf_occ1", spq.occupancy, 0);
        chk("uf_flag1", spq.underflow, 1);
        step();
        spq.deq_pulse = 1'b0;
        chk("uf_occ2", spq.occupancy, 0);
        step();
        chk("uf_sticky", spq.underflow, 1);
        chk("uf_empty", spq.empty, 1);
        do_reset();
        chk("uf_cleared", spq.underflow, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
